serial_rx_frame_ctrl: RTL

Oversampling receive controller for the serial link. It detects the start bit on the raw line, generates mid-bit sample strobes, and sequences the start/data/parity/stop frame through a state machine. Accepted bytes go into a small FIFO with a valid/ready drain interface toward the host logic. Parity, framing and overflow conditions are reported as single-cycle pulses.

---
 rtl/serial_rx_frame_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_rx_frame_ctrl.sv
// Oversampling serial receiver: start-bit detection, frame FSM, and a small output FIFO.
// Define SERIAL_RX_PARITY_EN to add the odd-parity bit (11-bit frame); the default build uses a 10-bit frame.
module serial_rx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_overflow,
    output logic       o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rxd_m, rxd_s;
    logic          bit_end, stop_sample, parity_ok;
    logic          push, pop, full;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW:0]   count, count_next;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= i_rxd;
            rxd_s <= rxd_m;
        end
    end

    assign bit_end     = (cnt == CNT_LAST);
    assign stop_sample = (state == STOP) && bit_end;
    assign pop         = o_valid && i_ready;
    assign full        = (count == CNT_FULL);

`ifdef SERIAL_RX_PARITY_EN
    logic par;
    assign parity_ok = ^{shreg, par};
`else
    assign parity_ok    = 1'b1;
    assign o_parity_err = 1'b0;
`endif

    // A full FIFO still accepts the byte when the head is popped in the same cycle.
    assign push = stop_sample && rxd_s && parity_ok && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
            o_busy      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par          <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state  <= START;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rxd_s;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        par   <= rxd_s;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            o_frame_err <= 1'b1;
                            state       <= BREAK;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            if (!parity_ok) begin
`ifdef SERIAL_RX_PARITY_EN
                                o_parity_err <= 1'b1;
`endif
                            end else if (!push) begin
                                o_overflow <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxd_s) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; pointers and count define validity, so only they need reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    assign rd_next = rd_ptr + 1'b1;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_data  <= 8'h00;
            o_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_next;
            count   <= count_next;
            o_valid <= (count_next != '0);
            // Registered head: load the incoming byte when it becomes the head, else the next stored entry.
            if (count == '0 || (pop && count == (AW + 1)'(1))) begin
                if (push) o_data <= shreg;
            end else if (pop) begin
                o_data <= mem[rd_next];
            end
        end
    end

endmodule
